// File: rtl/fu_mem_access_ctrl_pkg.sv
// Shared types and constants for the FU data-memory access controller.
package fu_mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } mem_state_e;

    localparam int PidWidth    = 2;
    localparam int MaskWidth   = 4;
    localparam int Funct3Width = 3;

    localparam logic [Funct3Width-1:0] F3_LB  = 3'b000;
    localparam logic [Funct3Width-1:0] F3_LH  = 3'b001;
    localparam logic [Funct3Width-1:0] F3_LW  = 3'b010;
    localparam logic [Funct3Width-1:0] F3_LD  = 3'b011;
    localparam logic [Funct3Width-1:0] F3_LBU = 3'b100;
    localparam logic [Funct3Width-1:0] F3_LHU = 3'b101;
    localparam logic [Funct3Width-1:0] F3_LWU = 3'b110;

    // Bridge write-progress code that marks a finished store.
    localparam logic [2:0] WRITE_DONE = 3'b111;

endpackage

// File: rtl/fu_mem_access_ctrl_load_extend.sv
// Load-data lane extraction with sign/zero extension on a 64-bit RAM word.
module fu_mem_access_ctrl_load_extend
    import fu_mem_access_ctrl_pkg::*;
(
    input  logic [63:0]            rdata_i,
    input  logic [2:0]             offset_i,
    input  logic [Funct3Width-1:0] funct3_i,
    output logic [63:0]            data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] word_sel;

    // Offset bits below the access size are dropped, so misaligned loads alias down.
    assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{offset_i[2:1], 4'b0000} +: 16];
    assign word_sel = rdata_i[{offset_i[2], 5'b00000} +: 32];

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_LB:   data_o = {{56{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {56'd0, byte_sel};
            F3_LH:   data_o = {{48{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {48'd0, half_sel};
            F3_LW:   data_o = {{32{word_sel[31]}}, word_sel};
            F3_LWU:  data_o = {32'd0, word_sel};
            F3_LD:   data_o = rdata_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/fu_mem_access_ctrl.sv
// Round-robin arbiter between the two FU ways and a read/write/respond
// sequencer that owns the single data-RAM port.
module fu_mem_access_ctrl
    import fu_mem_access_ctrl_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter int NumWay    = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NumWay-1:0]                      valid_i,
    input  logic [NumWay-1:0][AddrWidth-1:0]       readAddr_i,
    input  logic [NumWay-1:0][AddrWidth-1:0]       writeAddr_i,
    input  logic [NumWay-1:0][DataWidth-1:0]       writeData_i,
    input  logic [NumWay-1:0][MaskWidth-1:0]       writeMask_i,
    input  logic [NumWay-1:0][Funct3Width-1:0]     funct3_i,
    input  logic [NumWay-1:0][PidWidth-1:0]        pID_i,
    output logic [NumWay-1:0]                      ready_o,
    output logic                                   ramReadEnable_o,
    output logic [AddrWidth-1:0]                   ramReadAddr_o,
    input  logic [DataWidth-1:0]                   ramReadData_i,
    input  logic                                   dataOk_i,
    output logic                                   ramWriteEnable_o,
    output logic [AddrWidth-1:0]                   ramWriteAddr_o,
    output logic [DataWidth-1:0]                   ramWriteData_o,
    output logic [MaskWidth-1:0]                   ramWriteMask_o,
    input  logic [2:0]                             writeState_i,
    output logic                                   loadValid_o,
    output logic [DataWidth-1:0]                   loadData_o,
    output logic                                   loadWay_o,
    output logic [PidWidth-1:0]                    loadPID_o,
    output logic                                   busy_o
);

    mem_state_e                 state_q;
    logic                       rr_last_q;
    logic                       way_q;
    logic [AddrWidth-1:0]       rd_addr_q;
    logic [AddrWidth-1:0]       wr_addr_q;
    logic [DataWidth-1:0]       wr_data_q;
    logic [MaskWidth-1:0]       wr_mask_q;
    logic [Funct3Width-1:0]     funct3_q;
    logic [PidWidth-1:0]        pid_q;
    logic [DataWidth-1:0]       rdata_q;

    logic                       ram_rd_en_q;
    logic                       ram_wr_en_q;
    logic                       load_valid_q;
    logic [DataWidth-1:0]       load_data_q;
    logic                       load_way_q;
    logic [PidWidth-1:0]        load_pid_q;

    logic [NumWay-1:0]          req;
    logic                       idle;
    logic                       gnt_valid;
    logic                       gnt_way;
    logic                       rd_pending;
    logic                       wr_pending;
    logic [DataWidth-1:0]       ext_src;
    logic [DataWidth-1:0]       load_data_d;

    assign idle       = (state_q == IDLE);
    assign rd_pending = |rd_addr_q;
    assign wr_pending = |wr_addr_q;

    // A valid beat with both addresses zero is not a request: it is accepted
    // through ready_o but never starts an access.
    generate
        for (genvar gi = 0; gi < NumWay; gi++) begin : g_way
            localparam int Other = NumWay - 1 - gi;
            assign req[gi]     = valid_i[gi] & ((|readAddr_i[gi]) | (|writeAddr_i[gi]));
            assign ready_o[gi] = idle & ((gnt_valid & (gnt_way == 1'(gi))) | ~req[Other]);
        end
    endgenerate

    always_comb begin
        gnt_way = 1'b0;
        if (req[0] && req[1]) begin
            gnt_way = ~rr_last_q;
        end else if (req[1]) begin
            gnt_way = 1'b1;
        end
    end

    assign gnt_valid = idle & (|req);

    // On a direct READ->RESP hop the word is still on the RAM bus; after a
    // trailing store it comes from the latched copy.
    assign ext_src = (state_q == READ) ? ramReadData_i : rdata_q;

    fu_mem_access_ctrl_load_extend u_load_extend (
        .rdata_i  (ext_src),
        .offset_i (rd_addr_q[2:0]),
        .funct3_i (funct3_q),
        .data_o   (load_data_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_last_q    <= 1'b1;
            way_q        <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_mask_q    <= '0;
            funct3_q     <= '0;
            pid_q        <= '0;
            rdata_q      <= '0;
            ram_rd_en_q  <= 1'b0;
            ram_wr_en_q  <= 1'b0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            load_way_q   <= 1'b0;
            load_pid_q   <= '0;
        end else begin
            load_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        way_q     <= gnt_way;
                        rr_last_q <= gnt_way;
                        rd_addr_q <= readAddr_i[gnt_way];
                        wr_addr_q <= writeAddr_i[gnt_way];
                        wr_data_q <= writeData_i[gnt_way];
                        wr_mask_q <= writeMask_i[gnt_way];
                        funct3_q  <= funct3_i[gnt_way];
                        pid_q     <= pID_i[gnt_way];
                        if (|readAddr_i[gnt_way]) begin
                            state_q     <= READ;
                            ram_rd_en_q <= 1'b1;
                        end else begin
                            state_q     <= WRITE;
                            ram_wr_en_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (dataOk_i) begin
                        rdata_q     <= ramReadData_i;
                        ram_rd_en_q <= 1'b0;
                        if (wr_pending) begin
                            state_q     <= WRITE;
                            ram_wr_en_q <= 1'b1;
                        end else begin
                            state_q      <= RESP;
                            load_valid_q <= 1'b1;
                            load_data_q  <= load_data_d;
                            load_way_q   <= way_q;
                            load_pid_q   <= pid_q;
                        end
                    end
                end
                WRITE: begin
                    if (writeState_i == WRITE_DONE) begin
                        ram_wr_en_q <= 1'b0;
                        if (rd_pending) begin
                            state_q      <= RESP;
                            load_valid_q <= 1'b1;
                            load_data_q  <= load_data_d;
                            load_way_q   <= way_q;
                            load_pid_q   <= pid_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ramReadEnable_o  = ram_rd_en_q;
    assign ramReadAddr_o    = rd_addr_q;
    assign ramWriteEnable_o = ram_wr_en_q;
    assign ramWriteAddr_o   = wr_addr_q;
    assign ramWriteData_o   = wr_data_q;
    assign ramWriteMask_o   = wr_mask_q;
    assign loadValid_o      = load_valid_q;
    assign loadData_o       = load_data_q;
    assign loadWay_o        = load_way_q;
    assign loadPID_o        = load_pid_q;
    assign busy_o           = ~idle;

endmodule

// File: tb/tb_fu_mem_access_ctrl.sv
// Directed bench for fu_mem_access_ctrl: an operation-queue reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_fu_mem_access_ctrl;

    logic              clk;
    logic              reset_n;
    logic [1:0]        valid_i;
    logic [1:0][31:0]  readAddr_i;
    logic [1:0][31:0]  writeAddr_i;
    logic [1:0][63:0]  writeData_i;
    logic [1:0][3:0]   writeMask_i;
    logic [1:0][2:0]   funct3_i;
    logic [1:0][1:0]   pID_i;
    logic [1:0]        ready_o;
    logic              ramReadEnable_o;
    logic [31:0]       ramReadAddr_o;
    logic [63:0]       ramReadData_i;
    logic              dataOk_i;
    logic              ramWriteEnable_o;
    logic [31:0]       ramWriteAddr_o;
    logic [63:0]       ramWriteData_o;
    logic [3:0]        ramWriteMask_o;
    logic [2:0]        writeState_i;
    logic              loadValid_o;
    logic [63:0]       loadData_o;
    logic              loadWay_o;
    logic [1:0]        loadPID_o;
    logic              busy_o;

    fu_mem_access_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_i          (valid_i),
        .readAddr_i       (readAddr_i),
        .writeAddr_i      (writeAddr_i),
        .writeData_i      (writeData_i),
        .writeMask_i      (writeMask_i),
        .funct3_i         (funct3_i),
        .pID_i            (pID_i),
        .ready_o          (ready_o),
        .ramReadEnable_o  (ramReadEnable_o),
        .ramReadAddr_o    (ramReadAddr_o),
        .ramReadData_i    (ramReadData_i),
        .dataOk_i         (dataOk_i),
        .ramWriteEnable_o (ramWriteEnable_o),
        .ramWriteAddr_o   (ramWriteAddr_o),
        .ramWriteData_o   (ramWriteData_o),
        .ramWriteMask_o   (ramWriteMask_o),
        .writeState_i     (writeState_i),
        .loadValid_o      (loadValid_o),
        .loadData_o       (loadData_o),
        .loadWay_o        (loadWay_o),
        .loadPID_o        (loadPID_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // Reference model: an accepted request becomes a list of pending steps
    // (read, write, respond) consumed in order as the memory side completes them.
    localparam int OP_RD  = 1;
    localparam int OP_WR  = 2;
    localparam int OP_RSP = 3;

    int          ops[$];
    int          m_rr = 1;
    int          m_way;
    logic [31:0] m_ra, m_wa;
    logic [63:0] m_wd, m_rdata;
    logic [3:0]  m_wm;
    logic [2:0]  m_f3;
    logic [1:0]  m_pid;

    function automatic logic [63:0] f_ext(input logic [63:0] d, input logic [2:0] off, input logic [2:0] f3);
        int          size;
        int          lo;
        logic [63:0] v;
        logic [63:0] msk;
        if (f3 == 3'b111) return 64'd0;
        size = 1 << f3[1:0];
        lo   = (int'(off) / size) * size;
        v    = d >> (lo * 8);
        if (size < 8) begin
            msk = (64'd1 << (size * 8)) - 64'd1;
            v   = v & msk;
            if (!f3[2] && v[size * 8 - 1]) v = v | ~msk;
        end
        return v;
    endfunction

    function automatic logic [1:0] m_req();
        logic [1:0] r;
        for (int w = 0; w < 2; w++)
            r[w] = valid_i[w] && (readAddr_i[w] != 0 || writeAddr_i[w] != 0);
        return r;
    endfunction

    function automatic logic [1:0] exp_ready();
        logic [1:0] rq;
        logic [1:0] r;
        rq = m_req();
        for (int w = 0; w < 2; w++)
            r[w] = (ops.size() == 0) && (!rq[1 - w] || (rq[w] && (w != m_rr)));
        return r;
    endfunction

    task automatic model_step();
        logic [1:0] rq;
        int         g;
        if (!reset_n) begin
            ops.delete();
            m_rr = 1;
            return;
        end
        if (ops.size() == 0) begin
            rq = m_req();
            if (rq != 2'b00) begin
                if (rq == 2'b11) g = (m_rr == 1) ? 0 : 1;
                else             g = rq[1] ? 1 : 0;
                m_way = g;
                m_rr  = g;
                m_ra  = readAddr_i[g];
                m_wa  = writeAddr_i[g];
                m_wd  = writeData_i[g];
                m_wm  = writeMask_i[g];
                m_f3  = funct3_i[g];
                m_pid = pID_i[g];
                if (m_ra != 0) ops.push_back(OP_RD);
                if (m_wa != 0) ops.push_back(OP_WR);
                if (m_ra != 0) ops.push_back(OP_RSP);
            end
        end else begin
            case (ops[0])
                OP_RD:  if (dataOk_i) begin m_rdata = ramReadData_i; void'(ops.pop_front()); end
                OP_WR:  if (writeState_i == 3'b111) void'(ops.pop_front());
                default: void'(ops.pop_front());
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    task automatic compare_cycle();
        int head;
        head = (ops.size() != 0) ? ops[0] : 0;
        chk("busy", busy_o, ops.size() != 0);
        chk("rd_en", ramReadEnable_o, head == OP_RD);
        chk("wr_en", ramWriteEnable_o, head == OP_WR);
        chk("load_valid", loadValid_o, head == OP_RSP);
        if (head == OP_RD) chk("rd_addr", ramReadAddr_o, m_ra);
        if (head == OP_WR) begin
            chk("wr_addr", ramWriteAddr_o, m_wa);
            chk("wr_data", ramWriteData_o, m_wd);
            chk("wr_mask", ramWriteMask_o, m_wm);
        end
        if (head == OP_RSP) begin
            chk("load_data", loadData_o, f_ext(m_rdata, m_ra[2:0], m_f3));
            chk("load_way", loadWay_o, m_way[0]);
            chk("load_pid", loadPID_o, m_pid);
        end
        chk("ready", ready_o, exp_ready());
        if (m_req() == 2'b11) chk("ready_excl", ready_o == 2'b11, 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (reset_n) compare_cycle();
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_load(input int w, input logic [31:0] ra, input logic [2:0] f3, input logic [1:0] pid,
                            input logic [63:0] d, input int rd_wait,
                            output logic [63:0] got, output logic gw, output logic [1:0] gp, output int lat);
        valid_i[w]     = 1'b1;
        readAddr_i[w]  = ra;
        writeAddr_i[w] = 32'd0;
        funct3_i[w]    = f3;
        pID_i[w]       = pid;
        lat = 1;
        cyc(1);
        lat++;
        valid_i[w] = 1'b0;
        repeat (rd_wait) begin
            cyc(1);
            lat++;
        end
        ramReadData_i = d;
        dataOk_i      = 1'b1;
        cyc(1);
        lat++;
        dataOk_i = 1'b0;
        for (int i = 0; i < 8 && !loadValid_o; i++) begin
            cyc(1);
            lat++;
        end
        chk("load_seen", loadValid_o, 1'b1);
        got = loadData_o;
        gw  = loadWay_o;
        gp  = loadPID_o;
        $display("load way%0d addr=%h f3=%0d data=%h -> %h lat=%0d", w, ra, f3, d, got, lat);
        cyc(1);
    endtask

    task automatic wait_wr_en(input string nm);
        int k;
        k = 0;
        while (!ramWriteEnable_o && k < 10) begin
            cyc(1);
            k++;
        end
        if (k == 10) chk(nm, ramWriteEnable_o, 1'b1);
    endtask

    typedef struct {
        logic [31:0] ra;
        logic [2:0]  f3;
        logic [63:0] d;
        logic [63:0] e;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [63:0] got;
        logic        gw;
        logic [1:0]  gp;
        int          lat;
        int          seq[4];

        reset_n       = 1'b0;
        valid_i       = '0;
        readAddr_i    = '0;
        writeAddr_i   = '0;
        writeData_i   = '0;
        writeMask_i   = '0;
        funct3_i      = '0;
        pID_i         = '0;
        ramReadData_i = '0;
        dataOk_i      = 1'b0;
        writeState_i  = 3'd0;

        vecs[0] = '{32'h0000_1004, 3'b110, 64'hDEAD_BEEF_1234_5678, 64'h0000_0000_DEAD_BEEF};
        vecs[1] = '{32'h0000_1004, 3'b010, 64'hDEAD_BEEF_1234_5678, 64'hFFFF_FFFF_DEAD_BEEF};
        vecs[2] = '{32'h0000_1000, 3'b010, 64'hDEAD_BEEF_1234_5678, 64'h0000_0000_1234_5678};
        vecs[3] = '{32'h0000_2006, 3'b001, 64'h8001_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_8001};
        vecs[4] = '{32'h0000_2007, 3'b101, 64'h8001_0000_0000_00FF, 64'h0000_0000_0000_8001};
        vecs[5] = '{32'h0000_2000, 3'b100, 64'h8001_0000_0000_00FF, 64'h0000_0000_0000_00FF};
        vecs[6] = '{32'h0000_2000, 3'b000, 64'h8001_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{32'h0000_2003, 3'b111, 64'h8001_0000_0000_00FF, 64'h0000_0000_0000_0000};
        vecs[8] = '{32'h0000_2005, 3'b011, 64'h8001_0000_0000_00FF, 64'h8001_0000_0000_00FF};

        // Reset values
        cyc(2);
        chk("rst_rd_en", ramReadEnable_o, 0);
        chk("rst_wr_en", ramWriteEnable_o, 0);
        chk("rst_rd_addr", ramReadAddr_o, 0);
        chk("rst_wr_addr", ramWriteAddr_o, 0);
        chk("rst_wr_data", ramWriteData_o, 0);
        chk("rst_wr_mask", ramWriteMask_o, 0);
        chk("rst_lv", loadValid_o, 0);
        chk("rst_ld", loadData_o, 0);
        chk("rst_lway", loadWay_o, 0);
        chk("rst_lpid", loadPID_o, 0);
        chk("rst_busy", busy_o, 0);
        $display("reset: outputs checked");
        reset_n = 1'b1;
        cyc(1);

        // Both ways stream stores: grants must alternate starting at way0
        valid_i        = 2'b11;
        writeAddr_i[0] = 32'h0000_0200;
        writeAddr_i[1] = 32'h0000_0300;
        writeData_i[0] = 64'h1111_2222_3333_4444;
        writeData_i[1] = 64'h5555_6666_7777_8888;
        writeMask_i[0] = 4'h3;
        writeMask_i[1] = 4'h2;
        for (int t = 0; t < 4; t++) begin
            wait_wr_en("rr_wr_timeout");
            seq[t] = (ramWriteAddr_o == 32'h0000_0300) ? 1 : 0;
            if (t == 3) valid_i = 2'b00;
            cyc(2);
            chk("rr_wr_hold", ramWriteEnable_o, 1);
            writeState_i = 3'b111;
            cyc(1);
            writeState_i = 3'd0;
            chk("rr_wr_drop", ramWriteEnable_o, 0);
            $display("store grant %0d -> way%0d", t, seq[t]);
        end
        for (int t = 0; t < 4; t++) chk("rr_order", seq[t], t % 2);
        writeAddr_i = '0;
        cyc(2);

        // Single signed byte load on way0, minimum latency
        run_load(0, 32'h8000_0005, 3'b000, 2'd2, 64'h0000_8000_0000_0000, 0, got, gw, gp, lat);
        chk("lb_data", got, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_way", gw, 0);
        chk("lb_pid", gp, 2'd2);
        chk("lb_latency", lat, 3);
        chk("lb_idle_after", busy_o, 0);

        // Extraction table on way1 with varying read latency
        for (int i = 0; i < 9; i++) begin
            run_load(1, vecs[i].ra, vecs[i].f3, 2'(i), vecs[i].d, i % 3, got, gw, gp, lat);
            chk("ext_data", got, vecs[i].e);
            chk("ext_way", gw, 1);
        end

        // Load+store on way1: read, then write, then respond
        valid_i[1]     = 1'b1;
        readAddr_i[1]  = 32'h0000_0100;
        writeAddr_i[1] = 32'h0000_0108;
        writeData_i[1] = 64'hA5A5_0000_FFFF_1234;
        writeMask_i[1] = 4'h3;
        funct3_i[1]    = 3'b011;
        pID_i[1]       = 2'd3;
        cyc(1);
        valid_i[1] = 1'b0;
        chk("ls_rd_en", ramReadEnable_o, 1);
        chk("ls_rd_addr", ramReadAddr_o, 32'h0000_0100);
        writeState_i = 3'b111;
        cyc(1);
        writeState_i = 3'd0;
        chk("ls_stray_ws_rd_en", ramReadEnable_o, 1);
        chk("ls_stray_ws_wr_en", ramWriteEnable_o, 0);
        chk("ls_stray_ws_lv", loadValid_o, 0);
        ramReadData_i = 64'h0123_4567_89AB_CDEF;
        dataOk_i      = 1'b1;
        cyc(1);
        dataOk_i      = 1'b0;
        ramReadData_i = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("ls_wr_en", ramWriteEnable_o, 1);
        chk("ls_rd_off", ramReadEnable_o, 0);
        chk("ls_wr_addr", ramWriteAddr_o, 32'h0000_0108);
        chk("ls_no_lv", loadValid_o, 0);
        cyc(1);
        writeState_i = 3'b111;
        cyc(1);
        writeState_i = 3'd0;
        chk("ls_lv", loadValid_o, 1);
        chk("ls_data", loadData_o, 64'h0123_4567_89AB_CDEF);
        chk("ls_pid", loadPID_o, 2'd3);
        chk("ls_way", loadWay_o, 1);
        $display("load+store way1 -> data=%h pid=%0d", loadData_o, loadPID_o);
        cyc(1);
        chk("ls_lv_once", loadValid_o, 0);
        chk("ls_idle", busy_o, 0);
        readAddr_i  = '0;
        writeAddr_i = '0;

        // Stray dataOk while idle
        ramReadData_i = 64'hCAFE_CAFE_CAFE_CAFE;
        dataOk_i      = 1'b1;
        cyc(1);
        dataOk_i = 1'b0;
        chk("stray_ok_busy", busy_o, 0);
        chk("stray_ok_lv", loadValid_o, 0);
        cyc(1);
        chk("stray_ok_lv2", loadValid_o, 0);
        $display("stray dataOk in idle: busy=%0d lv=%0d", busy_o, loadValid_o);

        // Asynchronous reset during a way0 store
        valid_i[0]     = 1'b1;
        writeAddr_i[0] = 32'h0000_0400;
        writeData_i[0] = 64'h0BAD_F00D_0BAD_F00D;
        cyc(1);
        valid_i[0] = 1'b0;
        chk("arst_pre_wr_en", ramWriteEnable_o, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_wr_en", ramWriteEnable_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_wr_addr", ramWriteAddr_o, 0);
        $display("async reset mid-write: wr_en=%0d busy=%0d", ramWriteEnable_o, busy_o);
        cyc(1);
        reset_n        = 1'b1;
        valid_i        = 2'b11;
        writeAddr_i[0] = 32'h0000_0200;
        writeAddr_i[1] = 32'h0000_0300;
        cyc(1);
        valid_i = 2'b00;
        chk("arst_next_grant_en", ramWriteEnable_o, 1);
        chk("arst_next_grant_way0", ramWriteAddr_o, 32'h0000_0200);
        $display("post-reset grant addr=%h", ramWriteAddr_o);
        writeState_i = 3'b111;
        cyc(1);
        writeState_i = 3'd0;
        writeAddr_i  = '0;
        cyc(3);
        chk("final_idle", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog at %0t: got=timeout want=finish", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fu_mem_access_ctrl.md
Name: fu_mem_access_ctrl

Overview:
Arbitrates the single data-RAM port between the way0 and way1 FU register stages and sequences each memory access. It accepts one request at a time with round-robin priority and drives the RAM read or write strobes until the access completes. Load data is extracted and sign- or zero-extended per funct3, then returned with the originating way and pID. It sits between the FU register stages and the data RAM/AXI bridge and supplies the ready that back-pressures both ways.

Parameters:
AddrWidth, 32, RAM byte address width
DataWidth, 64, RAM data width; the extraction logic is fixed to 64
NumWay, 2, number of requesting ways; fixed at 2 in this revision

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
valid_i  in  [NumWay]  per-way request valid
readAddr_i  in  [NumWay][32]  load address; non-zero means load
writeAddr_i  in  [NumWay][32]  store address; non-zero means store
writeData_i  in  [NumWay][64]  store data, already lane-aligned
writeMask_i  in  [NumWay][4]  store size code, passed through
funct3_i  in  [NumWay][3]  load type
pID_i  in  [NumWay][2]  instruction tag
ready_o  out  [NumWay]  per-way accept
ramReadEnable_o  out  1  read strobe
ramReadAddr_o  out  32  read address
ramReadData_i  in  64  read data
dataOk_i  in  1  read complete, 1-cycle pulse
ramWriteEnable_o  out  1  write strobe
ramWriteAddr_o  out  32
ramWriteData_o  out  64
ramWriteMask_o  out  4
writeState_i  in  3  write progress; 3'b111 means write done
loadValid_o  out  1  1-cycle load result pulse
loadData_o  out  64  extended load result
loadWay_o  out  1  way of the load result
loadPID_o  out  2  pID of the load result
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, rrLast=1 (way0 wins first). All outputs 0: strobes, addresses, data, load* and busy_o.
- A request from way w is valid_i[w] & (|readAddr_i[w] | |writeAddr_i[w]). A valid_i with both addresses zero is consumed with no access.
- ready_o[w] is combinational: 1 only in IDLE, and only when w is granted or the other way is not requesting.
- Arbitration, in IDLE:
  - Both ways requesting: grant ~rrLast.
  - One way requesting: grant that way.
  - On grant, capture the way's fields into internal regs and set rrLast=grant.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE -> READ when the captured readAddr != 0. Else IDLE -> WRITE when the captured writeAddr != 0.
  - READ: ramReadEnable_o=1 and ramReadAddr_o held. On dataOk_i, latch ramReadData_i. If the captured writeAddr != 0 go to WRITE, else go to RESP.
  - WRITE: ramWriteEnable_o=1 with addr/data/mask held. When writeState_i==3'b111, go to RESP if a load is pending, else to IDLE.
  - RESP: loadValid_o=1 for exactly one cycle, then IDLE. A load+store request therefore issues the read first, then the write, and responds last.
- Strobes are registered: they assert the cycle after the grant and deassert the cycle after completion.
- Minimum load latency: grant cycle, then 1 READ cycle with dataOk, then RESP, so loadValid_o comes 3 cycles after acceptance.
- Load extraction: off=readAddr[2:0].
  - funct3 000 LB, 100 LBU: byte at off*8.
  - 001 LH, 101 LHU: half at off[2:1]*16.
  - 010 LW, 110 LWU: word at off[2]*32.
  - 011 LD: full 64 bits.
  - Signed variants sign-extend, unsigned variants zero-extend. Misalignment is not checked: the low offset bits beyond the access size are ignored. funct3 111 returns 0.
- dataOk_i or writeState_i==111 outside READ/WRITE is ignored.
- A new request is never accepted in RESP. Its ready stays low until IDLE.
- Async reset mid-access returns to IDLE immediately, drops the strobes and discards the captured request without a response.

Decomposition:
- Shared package: mem_state_e enum {IDLE, READ, WRITE, RESP}, funct3 load constants (LB…LWU), WRITE_DONE=3'b111.
- One sub-module: load_extend, combinational (rdata, offset, funct3 -> data).
- The arbiter stays inline.

Test Plan:
- Single load: way0 readAddr=0x8000_0005, funct3=000, dataOk_i with data 0x0000_8000_0000_0000 -> byte 5 = 0x80 is extracted, loadData_o=0xFFFF_FFFF_FFFF_FF80, loadWay_o=0, loadValid_o 3 cycles after acceptance.
- Both ways request continuously with writeAddr only -> grants alternate 0,1,0,1. Each WRITE holds until writeState_i=111, and ready_o never goes high for both ways in the same cycle.
- Load+store on way1 (readAddr=0x100, writeAddr=0x108, funct3=011) -> READ completes, then WRITE with ramWriteAddr_o=0x108, then loadValid_o=1 with the 64-bit data and loadPID_o equal to the captured pID.
- LWU at off=4 with data 0xDEAD_BEEF_1234_5678 -> 0x0000_0000_DEAD_BEEF. LW on the same data -> 0xFFFF_FFFF_DEAD_BEEF.
- Stray dataOk_i pulse in IDLE, and writeState_i=111 during READ -> no state change and no loadValid_o.
- reset_n low while in WRITE -> ramWriteEnable_o=0 asynchronously, busy_o=0, and the next grant goes to way0.
